// File: rtl/feature_collector_pkg.sv
// Shared definitions for the feature collector.
// - ADDR_WIDTH_DEF: default feature address width, {row, col}.
// - ROW_*/COL_*: bit positions of the row and column fields in an address.
// - sat_inc(): increment that sticks at a caller-supplied maximum.
package feature_collector_pkg;

  localparam int ADDR_WIDTH_DEF = 16;

  localparam int ROW_MSB = 15;
  localparam int ROW_LSB = 8;
  localparam int COL_MSB = 7;
  localparam int COL_LSB = 0;

  // Operates on a 64-bit container so one helper serves every counter width.
  // max_v is the all-ones value of the real counter width.
  function automatic logic [63:0] sat_inc(input logic [63:0] v,
                                          input logic [63:0] max_v);
    return (v >= max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/feature_collector_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   clear_i         synchronous flush; wins over push and pop
//   push_i, data_i  write request and data (ignored when full)
//   pop_i           read request (ignored when empty)
//   data_o          current head entry, valid while not empty
//   full_o, empty_o status flags
//   occupancy_o     number of stored entries, 0..DEPTH
module sync_fifo #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             do_push, do_pop;

  assign full_o      = (occ_q == OW'(DEPTH));
  assign empty_o     = (occ_q == '0);
  assign occupancy_o = occ_q;
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;

  // Head is forced to zero when empty so the port reads 0 out of reset
  // instead of uninitialised storage; an empty head is don't-care anyway.
  assign data_o = empty_o ? '0 : mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      // Pointer width equals log2(DEPTH), so increments wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + OW'(do_push) - OW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/feature_collector.sv
// feature_collector: terminal stage after nms5. Keeps windows flagged as
// features, optionally drops back-to-back duplicates, buffers survivors and
// streams them out with a valid/req handshake.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   clear                  synchronous flush of FIFO, counters, history, flag
//   in_isfeature/in_feature_addr/in_feature_valid   nms5 result
//   ready_for_new_feature  backpressure to nms5
//   out_feature_valid/out_feature_addr/out_feature_req   readout port
//   feature_count/reject_count/dup_count   saturating statistics
//   overflow_flag          sticky stall-watchdog flag
module feature_collector
  import feature_collector_pkg::*;
#(
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = 32,
  parameter bit DEDUP_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_isfeature,
  input  logic [ADDR_WIDTH-1:0] in_feature_addr,
  input  logic                  in_feature_valid,
  output logic                  ready_for_new_feature,
  output logic                  out_feature_valid,
  output logic [ADDR_WIDTH-1:0] out_feature_addr,
  input  logic                  out_feature_req,
  output logic [CNT_WIDTH-1:0]  feature_count,
  output logic [CNT_WIDTH-1:0]  reject_count,
  output logic [CNT_WIDTH-1:0]  dup_count,
  output logic                  overflow_flag
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [63:0] CNT_MAX = 64'({CNT_WIDTH{1'b1}});

  logic                  fifo_full, fifo_empty, unused_empty;
  logic [OW-1:0]         fifo_occ;
  logic                  acc, dup_hit, push, pop, stall;

  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic                  hist_valid_q, hist_valid_d;
  logic [CNT_WIDTH-1:0]  feat_cnt_q, feat_cnt_d;
  logic [CNT_WIDTH-1:0]  rej_cnt_q, rej_cnt_d;
  logic [CNT_WIDTH-1:0]  dup_cnt_q, dup_cnt_d;
  logic [OW-1:0]         stall_cnt_q, stall_cnt_d;
  logic                  ovf_q, ovf_d;

  assign unused_empty = fifo_empty;

  assign ready_for_new_feature = ~fifo_full & ~clear;
  assign acc     = in_feature_valid & ready_for_new_feature;
  assign dup_hit = DEDUP_EN & hist_valid_q & (in_feature_addr == last_addr_q);
  assign push    = acc & in_isfeature & ~dup_hit;
  assign out_feature_valid = (fifo_occ != '0);
  assign pop     = out_feature_valid & out_feature_req;
  assign stall   = in_feature_valid & ~ready_for_new_feature;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear),
    .push_i      (push),
    .data_i      (in_feature_addr),
    .pop_i       (pop),
    .data_o      (out_feature_addr),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .occupancy_o (fifo_occ)
  );

  always_comb begin
    last_addr_d  = last_addr_q;
    hist_valid_d = hist_valid_q;
    feat_cnt_d   = feat_cnt_q;
    rej_cnt_d    = rej_cnt_q;
    dup_cnt_d    = dup_cnt_q;
    stall_cnt_d  = '0;
    ovf_d        = ovf_q;
    if (clear) begin
      last_addr_d  = '0;
      hist_valid_d = 1'b0;
      feat_cnt_d   = '0;
      rej_cnt_d    = '0;
      dup_cnt_d    = '0;
      ovf_d        = 1'b0;
    end else begin
      if (acc && !in_isfeature) begin
        rej_cnt_d = CNT_WIDTH'(sat_inc(64'(rej_cnt_q), CNT_MAX));
      end else if (acc && dup_hit) begin
        dup_cnt_d = CNT_WIDTH'(sat_inc(64'(dup_cnt_q), CNT_MAX));
      end else if (push) begin
        last_addr_d  = in_feature_addr;
        hist_valid_d = 1'b1;
        feat_cnt_d   = CNT_WIDTH'(sat_inc(64'(feat_cnt_q), CNT_MAX));
      end
      // Watchdog parks at FIFO_DEPTH so a very long stall cannot wrap it.
      if (stall) begin
        stall_cnt_d = (stall_cnt_q == OW'(FIFO_DEPTH)) ? stall_cnt_q
                                                       : stall_cnt_q + OW'(1);
      end
      if (stall_cnt_d == OW'(FIFO_DEPTH)) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr_q  <= '0;
      hist_valid_q <= 1'b0;
      feat_cnt_q   <= '0;
      rej_cnt_q    <= '0;
      dup_cnt_q    <= '0;
      stall_cnt_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      last_addr_q  <= last_addr_d;
      hist_valid_q <= hist_valid_d;
      feat_cnt_q   <= feat_cnt_d;
      rej_cnt_q    <= rej_cnt_d;
      dup_cnt_q    <= dup_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      ovf_q        <= ovf_d;
    end
  end

  assign feature_count = feat_cnt_q;
  assign reject_count  = rej_cnt_q;
  assign dup_count     = dup_cnt_q;
  assign overflow_flag = ovf_q;

endmodule

// File: tb/tb_feature_collector.sv
module tb_feature_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_isfeature = 1'b0;
  logic [15:0] in_feature_addr = '0;
  logic        in_feature_valid = 1'b0;
  logic        ready_for_new_feature;
  logic        out_feature_valid;
  logic [15:0] out_feature_addr;
  logic        out_feature_req = 1'b0;
  logic [31:0] feature_count, reject_count, dup_count;
  logic        overflow_flag;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  feature_collector #(
    .FIFO_DEPTH (256),
    .ADDR_WIDTH (16),
    .CNT_WIDTH  (32),
    .DEDUP_EN   (1'b1)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .clear                 (clear),
    .in_isfeature          (in_isfeature),
    .in_feature_addr       (in_feature_addr),
    .in_feature_valid      (in_feature_valid),
    .ready_for_new_feature (ready_for_new_feature),
    .out_feature_valid     (out_feature_valid),
    .out_feature_addr      (out_feature_addr),
    .out_feature_req       (out_feature_req),
    .feature_count         (feature_count),
    .reject_count          (reject_count),
    .dup_count             (dup_count),
    .overflow_flag         (overflow_flag)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", nm, act);
    end
  endtask

  // Monitor: every handshake on the readout port is checked against the
  // scoreboard queue filled by the stimulus.
  always @(negedge clk) begin
    if (rst_n && !clear && out_feature_valid && out_feature_req) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got 0x%0h, expected no output", out_feature_addr);
      end else begin
        check("pop_head", {16'h0, out_feature_addr}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // Call at posedge+#1; returns at posedge+#1 right after the accepting edge.
  task automatic send(input logic [15:0] a, input logic f);
    int n;
    n = 0;
    in_feature_valid = 1'b1;
    in_feature_addr  = a;
    in_isfeature     = f;
    @(negedge clk);
    while (!ready_for_new_feature && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!ready_for_new_feature) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: ready=0 after %0d cycles, expected 1", n);
    end
    @(posedge clk);
    #1;
    in_feature_valid = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    out_feature_req = 1'b1;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_feature_valid) && n < 1000) begin
      n++;
      @(negedge clk);
    end
    out_feature_req = 1'b0;
    check({nm, "_left"}, exp_q.size(), 0);
    check({nm, "_valid"}, {31'h0, out_feature_valid}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    out_feature_req = 1'b0;
    clear = 1'b1;
    @(negedge clk);
    check("ready_during_clear", {31'h0, ready_for_new_feature}, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_out_valid", {31'h0, out_feature_valid}, 0);
    check("rst_out_addr", {16'h0, out_feature_addr}, 0);
    check("rst_feature_count", feature_count, 0);
    check("rst_reject_count", reject_count, 0);
    check("rst_dup_count", dup_count, 0);
    check("rst_overflow", {31'h0, overflow_flag}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_ready", {31'h0, ready_for_new_feature}, 1);

    // Basic classification with the readout draining continuously
    out_feature_req = 1'b1;
    exp_q.push_back(16'h0102);
    send(16'h0102, 1'b1);
    send(16'h0103, 1'b0);
    exp_q.push_back(16'h0204);
    send(16'h0204, 1'b1);
    drain("basic");
    check("basic_feature_count", feature_count, 2);
    check("basic_reject_count", reject_count, 1);

    // Deduplication of back-to-back addresses
    do_clear();
    exp_q.push_back(16'h0505);
    exp_q.push_back(16'h0506);
    send(16'h0505, 1'b1);
    send(16'h0505, 1'b1);
    send(16'h0505, 1'b1);
    send(16'h0506, 1'b1);
    check("dedup_dup_count", dup_count, 2);
    check("dedup_feature_count", feature_count, 2);
    check("dedup_head", {16'h0, out_feature_addr}, 32'h0505);
    drain("dedup");

    // Fill to full, stall the source, watchdog, then drain
    do_clear();
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(16'(i));
      send(16'(i), 1'b1);
    end
    check("full_ready_low", {31'h0, ready_for_new_feature}, 0);
    check("full_head", {16'h0, out_feature_addr}, 32'h0000);
    in_feature_valid = 1'b1;
    in_feature_addr  = 16'h0100;
    in_isfeature     = 1'b1;
    exp_q.push_back(16'h0100);
    repeat (255) @(posedge clk);
    #1;
    check("wd_before_limit", {31'h0, overflow_flag}, 0);
    check("wd_held_not_taken", feature_count, 256);
    @(posedge clk);
    #1;
    check("wd_at_limit", {31'h0, overflow_flag}, 1);
    out_feature_req = 1'b1;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!ready_for_new_feature && n < 600) begin
        n++;
        @(negedge clk);
      end
      check("ready_after_pop", {31'h0, ready_for_new_feature}, 1);
      @(posedge clk);
      #1;
      in_feature_valid = 1'b0;
    end
    drain("full");
    check("full_feature_count", feature_count, 257);
    check("wd_sticky", {31'h0, overflow_flag}, 1);
    do_clear();
    check("clr_overflow", {31'h0, overflow_flag}, 0);
    check("clr_feature_count", feature_count, 0);
    check("clr_out_valid", {31'h0, out_feature_valid}, 0);

    // Latency and simultaneous push/pop at occupancy 1
    exp_q.push_back(16'h0909);
    in_feature_valid = 1'b1;
    in_feature_addr  = 16'h0909;
    in_isfeature     = 1'b1;
    @(negedge clk);
    check("no_fallthrough", {31'h0, out_feature_valid}, 0);
    @(posedge clk);
    #1;
    in_feature_valid = 1'b0;
    check("latency_valid", {31'h0, out_feature_valid}, 1);
    check("latency_addr", {16'h0, out_feature_addr}, 32'h0909);
    exp_q.push_back(16'h0A0A);
    in_feature_valid = 1'b1;
    in_feature_addr  = 16'h0A0A;
    out_feature_req  = 1'b1;
    @(negedge clk);
    check("pp_ready", {31'h0, ready_for_new_feature}, 1);
    @(posedge clk);
    #1;
    in_feature_valid = 1'b0;
    out_feature_req  = 1'b0;
    check("pp_valid", {31'h0, out_feature_valid}, 1);
    check("pp_head", {16'h0, out_feature_addr}, 32'h0A0A);
    out_feature_req = 1'b1;
    @(posedge clk);
    #1;
    out_feature_req = 1'b0;
    check("pp_occ_was_one", {31'h0, out_feature_valid}, 0);
    check("pp_left", exp_q.size(), 0);

    // Asynchronous reset with entries buffered
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(16'h1000 + 16'(i));
      send(16'h1000 + 16'(i), 1'b1);
    end
    check("pre_rst_count", feature_count, 12);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_out_valid", {31'h0, out_feature_valid}, 0);
    check("arst_feature_count", feature_count, 0);
    check("arst_reject_count", reject_count, 0);
    check("arst_dup_count", dup_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("arst_ready", {31'h0, ready_for_new_feature}, 1);
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
